// File: rtl/miss_req_pkg.sv
// miss_req_pkg: shared constants, FSM state type and beat-packing helpers
// for the MoldUDP64 retransmission request generator.
//   REQ_LEN_BYTES : bytes in one request (session 10 + seq 8 + count 2)
//   REQ_BEATS     : 64-bit beats per request
//   KEEP_LAST     : byte enables on the final beat
package miss_req_pkg;

  localparam int unsigned REQ_LEN_BYTES = 20;
  localparam int unsigned REQ_BEATS     = 3;
  localparam int unsigned BEAT_BYTES    = 8;
  localparam int unsigned MSG_W         = REQ_LEN_BYTES * 8;
  localparam int unsigned SESS_W        = 80;
  localparam int unsigned WIRE_SEQ_W    = 64;
  localparam int unsigned WIRE_CNT_W    = 16;

  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_LAST = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_BEAT2
  } state_e;

  // Whole request, message byte 0 in the most significant byte.
  function automatic logic [MSG_W-1:0] build_msg(
    input logic [SESS_W-1:0]     sid,
    input logic [WIRE_SEQ_W-1:0] seq,
    input logic [WIRE_CNT_W-1:0] cnt
  );
    return {sid, seq, cnt};
  endfunction

  // Beat 'beat' of the request, message byte 8*beat+j placed in data[8j+7:8j].
  function automatic logic [63:0] beat_data(
    input logic [MSG_W-1:0] msg,
    input int unsigned      beat
  );
    logic [63:0] d;
    int unsigned k;
    d = '0;
    for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
      k = beat * BEAT_BYTES + j;
      if (k < REQ_LEN_BYTES) begin
        d[8*j +: 8] = msg[MSG_W-1-8*k -: 8];
      end
    end
    return d;
  endfunction

  function automatic logic [7:0] beat_keep(input int unsigned beat);
    return (beat == REQ_BEATS - 1) ? KEEP_LAST : KEEP_FULL;
  endfunction

endpackage

// File: rtl/miss_req_fifo.sv
// miss_req_fifo: synchronous FIFO of pending miss events with first-word
// fall-through read data.
//   clk, reset       : clock, synchronous active-high reset
//   i_push, i_wdata  : write strobe / entry (ignored when full)
//   i_pop            : discard head entry (ignored when empty)
//   o_rdata          : head entry, valid while !o_empty
//   o_full, o_empty  : occupancy flags
module miss_req_fifo #(
  parameter int unsigned WIDTH = 208,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned LP_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LP_AW:0]   r_wr_ptr;
  logic [LP_AW:0]   r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  // Extra pointer bit separates full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[LP_AW] != r_rd_ptr[LP_AW]) &&
                   (r_wr_ptr[LP_AW-1:0] == r_rd_ptr[LP_AW-1:0]);
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr[LP_AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (LP_AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (LP_AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[LP_AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/miss_req_gen.sv
// miss_req_gen: turns sequence-gap events into 20-byte MoldUDP64
// retransmission requests streamed as three 64-bit beats.
//   clk, reset             : clock, synchronous active-high reset
//   miss_seq_num_*_i       : gap event (valid pulse, session, start, count)
//   req_v_o/req_ready_i    : beat handshake
//   req_data_o/keep/last   : beat payload, wire byte 0 in [7:0]
//   drop_o, drop_cnt_o     : overflow pulse and saturating drop counter
// Build option MISS_REQ_SPLIT_EN: counts larger than 2^ML_W-1 are split
// into several consecutive requests; otherwise the count is clipped.
module miss_req_gen
  import miss_req_pkg::*;
#(
  parameter int unsigned SID_W      = 80,
  parameter int unsigned SEQ_NUM_W  = 64,
  parameter int unsigned ML_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_seq_num_v_i,
  input  logic [SID_W-1:0]     miss_seq_num_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_seq_num_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_i,
  output logic                 req_v_o,
  input  logic                 req_ready_i,
  output logic [63:0]          req_data_o,
  output logic [7:0]           req_keep_o,
  output logic                 req_last_o,
  output logic                 drop_o,
  output logic [7:0]           drop_cnt_o
);

  localparam int unsigned LP_ENTRY_W = SID_W + 2 * SEQ_NUM_W;
  localparam logic [SEQ_NUM_W-1:0] LP_CNT_MAX =
    SEQ_NUM_W'((64'd1 << ML_W) - 64'd1);

  state_e               r_state;
  logic [SID_W-1:0]     r_sid;
  logic [SEQ_NUM_W-1:0] r_seq;
  logic [SEQ_NUM_W-1:0] r_rem;
  logic                 r_req_v;
  logic [63:0]          r_data;
  logic [7:0]           r_keep;
  logic                 r_last;
  logic                 r_drop;
  logic [7:0]           r_drop_cnt;

  logic                  w_evt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop_ev;
  logic                  w_accept;
  logic [LP_ENTRY_W-1:0] w_wdata;
  logic [LP_ENTRY_W-1:0] w_rdata;
  logic [SID_W-1:0]      w_head_sid;
  logic [SEQ_NUM_W-1:0]  w_head_seq;
  logic [SEQ_NUM_W-1:0]  w_head_rem;
  logic                  w_more;
  logic [SEQ_NUM_W-1:0]  w_next_seq;
  logic [SEQ_NUM_W-1:0]  w_next_rem;
  logic [MSG_W-1:0]      w_head_msg;
  logic [MSG_W-1:0]      w_cur_msg;
  logic [MSG_W-1:0]      w_next_msg;

  function automatic logic [SEQ_NUM_W-1:0] f_clip(input logic [SEQ_NUM_W-1:0] x);
    return (x > LP_CNT_MAX) ? LP_CNT_MAX : x;
  endfunction

  // Zero-count events are ignored; a full FIFO drops even if it pops this cycle.
  assign w_evt     = miss_seq_num_v_i && (miss_seq_num_cnt_i != '0);
  assign w_push    = w_evt && !w_full;
  assign w_drop_ev = w_evt && w_full;
  assign w_wdata   = {miss_seq_num_sid_i, miss_seq_num_start_i, miss_seq_num_cnt_i};

  miss_req_fifo #(
    .WIDTH (LP_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_sid = w_rdata[LP_ENTRY_W-1 -: SID_W];
  assign w_head_seq = w_rdata[2*SEQ_NUM_W-1 -: SEQ_NUM_W];
  assign w_head_rem = w_rdata[SEQ_NUM_W-1:0];

`ifdef MISS_REQ_SPLIT_EN
  // Another chunk follows when more than one request's worth remains.
  assign w_more     = (r_rem > LP_CNT_MAX);
  assign w_next_seq = r_seq + LP_CNT_MAX;
  assign w_next_rem = r_rem - LP_CNT_MAX;
`else
  assign w_more     = 1'b0;
  assign w_next_seq = r_seq;
  assign w_next_rem = r_rem;
`endif

  assign w_head_msg = build_msg(SESS_W'(w_head_sid), WIRE_SEQ_W'(w_head_seq),
                                WIRE_CNT_W'(f_clip(w_head_rem)));
  assign w_cur_msg  = build_msg(SESS_W'(r_sid), WIRE_SEQ_W'(r_seq),
                                WIRE_CNT_W'(f_clip(r_rem)));
  assign w_next_msg = build_msg(SESS_W'(r_sid), WIRE_SEQ_W'(w_next_seq),
                                WIRE_CNT_W'(f_clip(w_next_rem)));

  assign w_accept = r_req_v && req_ready_i;
  // Head stays in the FIFO until its final chunk's last beat is taken.
  assign w_pop    = (r_state == ST_BEAT2) && w_accept && !w_more;

  // Request FSM; each transition preloads the registered beat it enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sid      <= '0;
      r_seq      <= '0;
      r_rem      <= '0;
      r_req_v    <= 1'b0;
      r_data     <= '0;
      r_keep     <= '0;
      r_last     <= 1'b0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_drop <= w_drop_ev;
      if (w_drop_ev && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_sid   <= w_head_sid;
            r_seq   <= w_head_seq;
            r_rem   <= w_head_rem;
            r_state <= ST_BEAT0;
            r_req_v <= 1'b1;
            r_data  <= beat_data(w_head_msg, 32'd0);
            r_keep  <= beat_keep(32'd0);
            r_last  <= 1'b0;
          end
        end
        ST_BEAT0: begin
          if (w_accept) begin
            r_state <= ST_BEAT1;
            r_data  <= beat_data(w_cur_msg, 32'd1);
            r_keep  <= beat_keep(32'd1);
          end
        end
        ST_BEAT1: begin
          if (w_accept) begin
            r_state <= ST_BEAT2;
            r_data  <= beat_data(w_cur_msg, 32'd2);
            r_keep  <= beat_keep(32'd2);
            r_last  <= 1'b1;
          end
        end
        ST_BEAT2: begin
          if (w_accept) begin
            if (w_more) begin
              r_seq   <= w_next_seq;
              r_rem   <= w_next_rem;
              r_state <= ST_BEAT0;
              r_data  <= beat_data(w_next_msg, 32'd0);
              r_keep  <= beat_keep(32'd0);
              r_last  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_req_v <= 1'b0;
              r_data  <= '0;
              r_keep  <= '0;
              r_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req_v <= 1'b0;
        end
      endcase
    end
  end

  assign req_v_o    = r_req_v;
  assign req_data_o = r_data;
  assign req_keep_o = r_keep;
  assign req_last_o = r_last;
  assign drop_o     = r_drop;
  assign drop_cnt_o = r_drop_cnt;

endmodule
